wb_stage_ctrl: RTL and testbench

- Parametrised writeback stage for the Y86-64 pipeline. Merges the W pipeline register, register-file write-port generation, halt/exception state machine and retire counters into one block.
- Sits between memory_access and the decode-stage register file.
- Adds behaviour the current writeback stage lacks:
  - configurable data and register-address widths;
  - dstE/dstM write-collision resolution;
  - a sticky stopped state;
  - retire and bubble counters.

---
 rtl/y86_pkg.sv | 30 +++
 rtl/wb_pipe_reg.sv | 62 ++++++
 rtl/wb_stage_ctrl.sv | 105 ++++++++++
 tb/tb_wb_stage_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 status codes, icodes and the writeback FSM state type
package y86_pkg;
   typedef enum logic [2:0] {
      S_BUB = 3'd0,
      S_AOK = 3'd1,
      S_HLT = 3'd2,
      S_ADR = 3'd3,
      S_INS = 3'd4
   } stat_e;
   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;
   // RNONE is the all-ones register address at whatever width REG_AW gives,
   // so each user derives it locally as '1.
   typedef enum logic {
      RUN     = 1'b0,
      STOPPED = 1'b1
   } wb_state_e;
endpackage

// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: W pipeline register with hold > bubble > load priority
// Ports: clk_i/rst_n_i (async active-low), hold_i freezes, bubble_i loads a NOP,
//        d_*_i next contents from the M stage, q_*_o registered W contents.
module wb_pipe_reg
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int REG_AW = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              hold_i,
   input  logic              bubble_i,
   input  logic [2:0]        d_stat_i,
   input  logic [3:0]        d_icode_i,
   input  logic [DATA_W-1:0] d_valE_i,
   input  logic [DATA_W-1:0] d_valM_i,
   input  logic [REG_AW-1:0] d_dstE_i,
   input  logic [REG_AW-1:0] d_dstM_i,
   output logic [2:0]        q_stat_o,
   output logic [3:0]        q_icode_o,
   output logic [DATA_W-1:0] q_valE_o,
   output logic [DATA_W-1:0] q_valM_o,
   output logic [REG_AW-1:0] q_dstE_o,
   output logic [REG_AW-1:0] q_dstM_o
);
   logic [2:0]        stat_q, stat_d;
   logic [3:0]        icode_q, icode_d;
   logic [DATA_W-1:0] valE_q, valE_d, valM_q, valM_d;
   logic [REG_AW-1:0] dstE_q, dstE_d, dstM_q, dstM_d;
   always_comb begin
      stat_d  = hold_i ? stat_q  : bubble_i ? S_AOK : d_stat_i;
      icode_d = hold_i ? icode_q : bubble_i ? I_NOP : d_icode_i;
      valE_d  = hold_i ? valE_q  : bubble_i ? '0    : d_valE_i;
      valM_d  = hold_i ? valM_q  : bubble_i ? '0    : d_valM_i;
      dstE_d  = hold_i ? dstE_q  : bubble_i ? '1    : d_dstE_i;
      dstM_d  = hold_i ? dstM_q  : bubble_i ? '1    : d_dstM_i;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stat_q  <= S_AOK;
         icode_q <= I_NOP;
         valE_q  <= '0;
         valM_q  <= '0;
         dstE_q  <= '1;
         dstM_q  <= '1;
      end else begin
         stat_q  <= stat_d;
         icode_q <= icode_d;
         valE_q  <= valE_d;
         valM_q  <= valM_d;
         dstE_q  <= dstE_d;
         dstM_q  <= dstM_d;
      end
   end
   assign q_stat_o  = stat_q;
   assign q_icode_o = icode_q;
   assign q_valE_o  = valE_q;
   assign q_valM_o  = valM_q;
   assign q_dstE_o  = dstE_q;
   assign q_dstM_o  = dstM_q;
endmodule

// File: rtl/wb_stage_ctrl.sv
// wb_stage_ctrl: Y86-64 writeback stage - W register, regfile write ports, stop FSM, counters
// Ports: clk_i/rst_n_i (async active-low); stall_i/bubble_i W register control;
//        m_*_i M-stage results; W_*_o registered W contents; rf_* two regfile write
//        ports; cpu_stat_o/stopped_o architectural status; *_cnt_o perf counters.
// Macro WB_PERF_EN: when defined the retire/bubble counters exist, else they read 0.
module wb_stage_ctrl
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              stall_i,
   input  logic              bubble_i,
   input  logic [2:0]        m_stat_i,
   input  logic [3:0]        m_icode_i,
   input  logic [DATA_W-1:0] m_valE_i,
   input  logic [DATA_W-1:0] m_valM_i,
   input  logic [REG_AW-1:0] m_dstE_i,
   input  logic [REG_AW-1:0] m_dstM_i,
   output logic [2:0]        W_stat_o,
   output logic [3:0]        W_icode_o,
   output logic [DATA_W-1:0] W_valE_o,
   output logic [DATA_W-1:0] W_valM_o,
   output logic [REG_AW-1:0] W_dstE_o,
   output logic [REG_AW-1:0] W_dstM_o,
   output logic              rf_weE_o,
   output logic [REG_AW-1:0] rf_waddrE_o,
   output logic [DATA_W-1:0] rf_wdataE_o,
   output logic              rf_weM_o,
   output logic [REG_AW-1:0] rf_waddrM_o,
   output logic [DATA_W-1:0] rf_wdataM_o,
   output logic [2:0]        cpu_stat_o,
   output logic              stopped_o,
   output logic [CNT_W-1:0]  retired_cnt_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);
   localparam logic [REG_AW-1:0] RNONE = '1;
   wb_state_e state_q, state_d;
   logic run, aok, fault, collision;
   wb_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_wreg (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .hold_i    (!run || stall_i),
      .bubble_i  (bubble_i),
      .d_stat_i  (m_stat_i),
      .d_icode_i (m_icode_i),
      .d_valE_i  (m_valE_i),
      .d_valM_i  (m_valM_i),
      .d_dstE_i  (m_dstE_i),
      .d_dstM_i  (m_dstM_i),
      .q_stat_o  (W_stat_o),
      .q_icode_o (W_icode_o),
      .q_valE_o  (W_valE_o),
      .q_valM_o  (W_valM_o),
      .q_dstE_o  (W_dstE_o),
      .q_dstM_o  (W_dstM_o)
   );
   assign run       = (state_q == RUN);
   assign aok       = (W_stat_o == S_AOK);
   assign fault     = !aok && (W_stat_o != S_BUB);
   // popq %rsp writes the same register from both ports; the loaded value (M) wins
   assign collision = (W_dstE_o == W_dstM_o) && (W_dstE_o != RNONE);
   assign rf_weE_o    = (W_dstE_o != RNONE) && aok && run && !collision;
   assign rf_weM_o    = (W_dstM_o != RNONE) && aok && run;
   assign rf_waddrE_o = W_dstE_o;
   assign rf_wdataE_o = W_valE_o;
   assign rf_waddrM_o = W_dstM_o;
   assign rf_wdataM_o = W_valM_o;
   assign cpu_stat_o  = (W_stat_o == S_BUB) ? S_AOK : W_stat_o;
   assign stopped_o   = !run;
   always_comb begin
      state_d = (run && fault) ? STOPPED : state_q;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= RUN;
      else state_q <= state_d;
   end
`ifdef WB_PERF_EN
   logic [CNT_W-1:0] retired_q, retired_d, bubble_q, bubble_d;
   logic adv, is_bub;
   assign adv    = run && !stall_i;
   assign is_bub = (W_icode_o == I_NOP) && (W_dstE_o == RNONE) && (W_dstM_o == RNONE);
   always_comb begin
      bubble_d  = (adv && is_bub) ? bubble_q + CNT_W'(1) : bubble_q;
      retired_d = (adv && !is_bub && aok) ? retired_q + CNT_W'(1) : retired_q;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         retired_q <= '0;
         bubble_q  <= '0;
      end else begin
         retired_q <= retired_d;
         bubble_q  <= bubble_d;
      end
   end
   assign retired_cnt_o = retired_q;
   assign bubble_cnt_o  = bubble_q;
`else
   assign retired_cnt_o = '0;
   assign bubble_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_wb_stage_ctrl.sv
// tb_wb_stage_ctrl: directed + randomized check of wb_stage_ctrl against a behavioural model
module tb_wb_stage_ctrl;
   logic        clk_i = 1'b0, rst_n_i = 1'b0, stall_i = 1'b0, bubble_i = 1'b0;
   logic [2:0]  m_stat_i = 3'd1;
   logic [3:0]  m_icode_i = 4'd1;
   logic [63:0] m_valE_i = '0, m_valM_i = '0;
   logic [3:0]  m_dstE_i = 4'hF, m_dstM_i = 4'hF;
   logic [2:0]  W_stat_o, cpu_stat_o;
   logic [3:0]  W_icode_o, W_dstE_o, W_dstM_o, rf_waddrE_o, rf_waddrM_o;
   logic [63:0] W_valE_o, W_valM_o, rf_wdataE_o, rf_wdataM_o;
   logic        rf_weE_o, rf_weM_o, stopped_o;
   logic [31:0] retired_cnt_o, bubble_cnt_o;

   typedef struct {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [63:0] valE, valM;
      logic [3:0]  dstE, dstM;
   } wreg_t;

   wreg_t       mw;
   bit          mstop;
   logic [31:0] mret, mbub;
   int          total = 0, fails = 0;

   wb_stage_ctrl dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .bubble_i(bubble_i),
      .m_stat_i(m_stat_i), .m_icode_i(m_icode_i), .m_valE_i(m_valE_i), .m_valM_i(m_valM_i),
      .m_dstE_i(m_dstE_i), .m_dstM_i(m_dstM_i),
      .W_stat_o(W_stat_o), .W_icode_o(W_icode_o), .W_valE_o(W_valE_o), .W_valM_o(W_valM_o),
      .W_dstE_o(W_dstE_o), .W_dstM_o(W_dstM_o),
      .rf_weE_o(rf_weE_o), .rf_waddrE_o(rf_waddrE_o), .rf_wdataE_o(rf_wdataE_o),
      .rf_weM_o(rf_weM_o), .rf_waddrM_o(rf_waddrM_o), .rf_wdataM_o(rf_wdataM_o),
      .cpu_stat_o(cpu_stat_o), .stopped_o(stopped_o),
      .retired_cnt_o(retired_cnt_o), .bubble_cnt_o(bubble_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic wreg_t nop_w();
      wreg_t w;
      w.stat = 3'd1; w.icode = 4'd1; w.valE = '0; w.valM = '0; w.dstE = 4'hF; w.dstM = 4'hF;
      return w;
   endfunction

   task automatic model_reset();
      mw = nop_w(); mstop = 0; mret = '0; mbub = '0;
   endtask

   // One clock edge of the architectural rules, using the inputs present before the edge
   task automatic model_clock();
      bit halt_now;
      if (!mstop) begin
         if (!stall_i) begin
            if (mw.icode == 4'd1 && mw.dstE == 4'hF && mw.dstM == 4'hF) mbub = mbub + 1;
            else if (mw.stat == 3'd1) mret = mret + 1;
         end
         halt_now = (mw.stat > 3'd1);
         if (!stall_i) begin
            if (bubble_i) mw = nop_w();
            else begin
               mw.stat = m_stat_i; mw.icode = m_icode_i; mw.valE = m_valE_i;
               mw.valM = m_valM_i; mw.dstE = m_dstE_i; mw.dstM = m_dstM_i;
            end
         end
         mstop = halt_now;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic okw, we_e, we_m;
      logic [31:0] er, eb;
      okw  = (mw.stat == 3'd1) && !mstop;
      we_m = okw && (mw.dstM != 4'hF);
      we_e = okw && (mw.dstE != 4'hF) && (mw.dstE != mw.dstM);
`ifdef WB_PERF_EN
      er = mret; eb = mbub;
`else
      er = '0; eb = '0;
`endif
      chk("W_stat", 64'(W_stat_o), 64'(mw.stat));
      chk("W_icode", 64'(W_icode_o), 64'(mw.icode));
      chk("W_valE", W_valE_o, mw.valE);
      chk("W_valM", W_valM_o, mw.valM);
      chk("W_dstE", 64'(W_dstE_o), 64'(mw.dstE));
      chk("W_dstM", 64'(W_dstM_o), 64'(mw.dstM));
      chk("weE", 64'(rf_weE_o), 64'(we_e));
      chk("weM", 64'(rf_weM_o), 64'(we_m));
      chk("waddrE", 64'(rf_waddrE_o), 64'(mw.dstE));
      chk("waddrM", 64'(rf_waddrM_o), 64'(mw.dstM));
      chk("wdataE", rf_wdataE_o, mw.valE);
      chk("wdataM", rf_wdataM_o, mw.valM);
      chk("cpu_stat", 64'(cpu_stat_o), 64'(mw.stat == 3'd0 ? 3'd1 : mw.stat));
      chk("stopped", 64'(stopped_o), 64'(mstop));
      chk("retired_cnt", 64'(retired_cnt_o), 64'(er));
      chk("bubble_cnt", 64'(bubble_cnt_o), 64'(eb));
   endtask

   task automatic cyc();
      @(posedge clk_i);
      model_clock();
      #1;
      check_all();
   endtask

   task automatic drive(input logic [2:0] s, input logic [3:0] ic, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
      m_stat_i = s; m_icode_i = ic; m_valE_i = ve; m_valM_i = vm; m_dstE_i = de; m_dstM_i = dm;
   endtask

   task automatic drive_rand();
      logic [3:0] de;
      stall_i  = ($urandom_range(4) == 0);
      bubble_i = ($urandom_range(4) == 0);
      de = 4'($urandom_range(15));
      drive(($urandom_range(9) < 8) ? 3'd1 : 3'($urandom_range(4)), 4'($urandom_range(11)),
            {$urandom, $urandom}, {$urandom, $urandom}, de,
            ($urandom_range(3) == 0) ? de : 4'($urandom_range(15)));
   endtask

   initial begin
      model_reset();
      #12;
      check_all();
      chk("rst_W_icode", 64'(W_icode_o), 64'h1);
      rst_n_i = 1'b1;
      // OPq into %rbx
      drive(3'd1, 4'd6, 64'h2A, 64'h0, 4'd3, 4'hF);
      cyc();
      chk("t1_weE", 64'(rf_weE_o), 64'h1);
      chk("t1_wdataE", rf_wdataE_o, 64'h2A);
      chk("t1_weM", 64'(rf_weM_o), 64'h0);
      // popq %rsp: both ports name register 4
      drive(3'd1, 4'hB, 64'h108, 64'h55, 4'd4, 4'd4);
      cyc();
      chk("t2_weM", 64'(rf_weM_o), 64'h1);
      chk("t2_wdataM", rf_wdataM_o, 64'h55);
      chk("t2_weE", 64'(rf_weE_o), 64'h0);
      // stall holds W and counters
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(3'd1, 4'd6, {$urandom, $urandom}, 64'h0, 4'd5, 4'hF);
         cyc();
         chk("t3_hold_valE", W_valE_o, 64'h108);
      end
      bubble_i = 1'b1;
      cyc();
      chk("t3_stall_bubble_valM", W_valM_o, 64'h55);
      // bubble
      stall_i = 1'b0;
      cyc();
      chk("t4_icode", 64'(W_icode_o), 64'h1);
      chk("t4_dstE", 64'(W_dstE_o), 64'hF);
      bubble_i = 1'b0;
      drive(3'd3, 4'd6, 64'h77, 64'h0, 4'd2, 4'hF);
      cyc();
      chk("t5_weE", 64'(rf_weE_o), 64'h0);
      cyc();
      chk("t5_stopped", 64'(stopped_o), 64'h1);
      for (int i = 0; i < 3; i++) begin
         drive(3'd1, 4'd6, {$urandom, $urandom}, 64'h0, 4'd1, 4'hF);
         cyc();
         chk("t5_cpu_stat", 64'(cpu_stat_o), 64'h3);
      end
      // asynchronous reset between edges
      #2 rst_n_i = 1'b0;
      #1 model_reset();
      check_all();
      chk("t6_stopped", 64'(stopped_o), 64'h0);
      chk("t6_stat", 64'(W_stat_o), 64'h1);
      #1 rst_n_i = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (mstop && $urandom_range(2) == 0) begin
            rst_n_i = 1'b0;
            #1 model_reset();
            check_all();
            #1 rst_n_i = 1'b1;
         end
         drive_rand();
         cyc();
      end
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
